// File: rtl/transmitter_fifo.sv
// UART transmitter with a small word FIFO in front: queued words are sent back to back,
// with the in-flight word held in its own shift register so that new pushes cannot disturb it.
module transmitter_fifo #(
  parameter int WAIT      = 868,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         send_req,
  input  logic [DATA_BITS-1:0]         data,
  output logic                         ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         uart_tx
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(WAIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic ODD = (PARITY == 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [2:0]           state;
  logic [TW-1:0]        timer;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic [DATA_BITS-1:0] head;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 last_stop;

  assign head      = mem[rd_ptr];
  assign push      = send_req & ready;
  assign bit_end   = (timer == TW'(WAIT - 1));
  assign last_stop = (state == STOP) && bit_end && (bit_idx == IW'(STOP_BITS - 1));
  // A pop happens from IDLE or at the very end of a frame, so frames chain with no gap.
  assign pop       = (count != '0) && ((state == IDLE) || last_stop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10: begin
          count <= count + CW'(1);
          ready <= ((count + CW'(1)) != CW'(DEPTH));
        end
        2'b01: begin
          count <= count - CW'(1);
          ready <= 1'b1;
        end
        default: begin
          count <= count;
          ready <= ready;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      uart_tx <= 1'b1;
      busy    <= 1'b0;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else if (state == IDLE) begin
      if (pop) begin
        shift   <= head;
        par_bit <= (^head) ^ ODD;
        state   <= START;
        uart_tx <= 1'b0;
        busy    <= 1'b1;
        timer   <= '0;
      end
    end else if (!bit_end) begin
      timer <= timer + TW'(1);
    end else begin
      timer <= '0;
      case (state)
        START: begin
          state   <= DATA;
          uart_tx <= shift[0];
          shift   <= shift >> 1;
          bit_idx <= '0;
        end
        DATA: begin
          if (bit_idx != IW'(DATA_BITS - 1)) begin
            bit_idx <= bit_idx + IW'(1);
            uart_tx <= shift[0];
            shift   <= shift >> 1;
          end else if (PARITY != 0) begin
            state   <= PAR;
            uart_tx <= par_bit;
          end else begin
            state   <= STOP;
            uart_tx <= 1'b1;
            bit_idx <= '0;
          end
        end
        PAR: begin
          state   <= STOP;
          uart_tx <= 1'b1;
          bit_idx <= '0;
        end
        STOP: begin
          if (!last_stop) begin
            bit_idx <= bit_idx + IW'(1);
          end else if (pop) begin
            shift   <= head;
            par_bit <= (^head) ^ ODD;
            state   <= START;
            uart_tx <= 1'b0;
          end else begin
            state   <= IDLE;
            uart_tx <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
